// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the MIPS data memory (dm) and its lane
// helper (dm_lane).
//   - DM_* access codes carried on dm_op
//   - NUM_LANES / VEC_W describe the byte-lane layout of one 32-bit word
//   - dm_ext: sign/zero extension of a halfword or byte load value
package dm_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF_S = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE_S = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam int WORD_W    = NUM_LANES * VEC_W;

  // Extend a sub-word load value to 32 bits.
  //   half = 1 : v[15:0] is the value, else v[7:0]
  //   sgn  = 1 : replicate the value's MSB, else fill with zeros
  function automatic logic [WORD_W-1:0] dm_ext(input logic [15:0] v,
                                               input logic        half,
                                               input logic        sgn);
    logic [WORD_W-1:0] r;
    if (half) r = {{16{sgn & v[15]}}, v};
    else      r = {{24{sgn & v[7]}},  v[7:0]};
    return r;
  endfunction

endpackage

// File: rtl/dm_lane.sv
// dm_lane: combinational lane steering for dm.
// Store side: from dm_op and the byte offset, builds the byte enables and
// merges the store data into the currently stored word.
// Load side: picks the addressed half/byte out of the stored word and
// extends it as dm_op asks.
// Ports:
//   dm_op    in  3   access size/extension code
//   addr_lo  in  2   byte offset within the word
//   wdata    in  32  store data (low half/byte used for sub-word stores)
//   raw      in  32  current contents of the addressed word
//   be       out 4   byte enables of the store
//   wmerge   out 32  word to write back (raw with enabled lanes replaced)
//   ld_data  out 32  extended load value
module dm_lane
  import dm_pkg::*;
(
  input  logic [2:0]        dm_op,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] wdata,
  input  logic [WORD_W-1:0] raw,
  output logic [3:0]        be,
  output logic [WORD_W-1:0] wmerge,
  output logic [WORD_W-1:0] ld_data
);

  logic [NUM_LANES-1:0][VEC_W-1:0] wrep_v;
  logic [NUM_LANES-1:0][VEC_W-1:0] raw_v;
  logic [NUM_LANES-1:0][VEC_W-1:0] mrg_v;
  logic [15:0]                     half_v;
  logic [7:0]                      byte_v;

  assign raw_v = raw;

  // Store data is replicated across all lanes so the byte enables alone
  // decide which lanes take it.
  always_comb begin
    be     = 4'b1111;
    wrep_v = wdata;
    case (dm_op)
      DM_HALF_S, DM_HALF_U: begin
        be     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wrep_v = {2{wdata[15:0]}};
      end
      DM_BYTE_S, DM_BYTE_U: begin
        be     = 4'b0001 << addr_lo;
        wrep_v = {4{wdata[7:0]}};
      end
      default: begin
        be     = 4'b1111;
        wrep_v = wdata;
      end
    endcase
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign mrg_v[k] = be[k] ? wrep_v[k] : raw_v[k];
  end

  assign wmerge = mrg_v;

  // Load extraction
  assign half_v = addr_lo[1] ? raw[31:16] : raw[15:0];
  assign byte_v = raw_v[addr_lo];

  always_comb begin
    ld_data = raw;
    case (dm_op)
      DM_HALF_S: ld_data = dm_ext(half_v, 1'b1, 1'b1);
      DM_HALF_U: ld_data = dm_ext(half_v, 1'b1, 1'b0);
      DM_BYTE_S: ld_data = dm_ext({8'h00, byte_v}, 1'b0, 1'b1);
      DM_BYTE_U: ld_data = dm_ext({8'h00, byte_v}, 1'b0, 1'b0);
      default:   ld_data = raw;
    endcase
  end

endmodule

// File: rtl/dm.sv
// dm: data memory for the single-cycle MIPS CPU (MEM stage).
// 2**ADDR_W 32-bit words, byte addressed, little-endian lanes. Word,
// halfword and byte loads/stores; loads sign- or zero-extend per dm_op.
// Reads are combinational; writes and reset act on the rising clock edge.
// Upper address bits are ignored, so addresses wrap modulo the memory size.
// Optional feature (macro DM_ALIGN_CHECK_EN): adds the misalign output;
// misaligned stores are dropped and misaligned loads return 0.
// Ports:
//   clk      in  1   clock, rising edge
//   rst      in  1   synchronous active-high reset
//   dm_w     in  1   write enable
//   dm_r     in  1   read enable (rdata is 0 when low)
//   addr     in  32  byte address
//   wdata    in  32  store data
//   dm_op    in  3   access size/extension code (DM_* in dm_pkg)
//   rdata    out 32  load data
//   misalign out 1   misaligned access flag (DM_ALIGN_CHECK_EN only)
// Parameters:
//   ADDR_W    word-address width
//   INIT_ZERO 1: reset clears all words; 0: reset keeps contents
module dm
  import dm_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_w,
  input  logic              dm_r,
  input  logic [31:0]       addr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [2:0]        dm_op,
  output logic [WORD_W-1:0] rdata
`ifdef DM_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic [WORD_W-1:0] raw;
  logic [WORD_W-1:0] wmerge;
  logic [WORD_W-1:0] ld_data;
  logic [3:0]        be;
  logic              wr_en;
  logic              rd_en;

  assign idx = addr[ADDR_W+1:2];
  assign raw = mem[idx];

  // Address bits above the word index only exist to be ignored.
  if (ADDR_W < 30) begin : g_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];
  end

  dm_lane u_lane (
    .dm_op   (dm_op),
    .addr_lo (addr[1:0]),
    .wdata   (wdata),
    .raw     (raw),
    .be      (be),
    .wmerge  (wmerge),
    .ld_data (ld_data)
  );

  // wmerge already carries the unenabled lanes, so be is informational here.
  logic unused_be;
  assign unused_be = ^be;

`ifdef DM_ALIGN_CHECK_EN
  logic bad_align;

  always_comb begin
    bad_align = 1'b0;
    case (dm_op)
      DM_HALF_S, DM_HALF_U: bad_align = addr[0];
      DM_BYTE_S, DM_BYTE_U: bad_align = 1'b0;
      default:              bad_align = |addr[1:0];
    endcase
  end

  assign misalign = (dm_r | dm_w) & bad_align;
  assign wr_en    = dm_w & ~bad_align;
  assign rd_en    = dm_r & ~bad_align;
`else
  assign wr_en = dm_w;
  assign rd_en = dm_r;
`endif

  assign rdata = rd_en ? ld_data : '0;

  // Reset wins over a concurrent write; with INIT_ZERO=0 it only drops it.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (INIT_ZERO) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[idx] <= wmerge;
    end
  end

endmodule

// File: tb/tb_dm.sv
// tb_dm: directed self-checking bench for dm (default parameters).
module tb_dm;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        dm_w;
  logic        dm_r;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  dm_op;
  logic [31:0] rdata;
`ifdef DM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dm #(.ADDR_W(AW), .INIT_ZERO(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .dm_w  (dm_w),
    .dm_r  (dm_r),
    .addr  (addr),
    .wdata (wdata),
    .dm_op (dm_op),
    .rdata (rdata)
`ifdef DM_ALIGN_CHECK_EN
    ,
    .misalign (misalign)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Store: inputs set mid-cycle, committed at the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    addr = a; wdata = d; dm_op = op; dm_w = 1'b1; dm_r = 1'b0;
    @(posedge clk); #1;
    dm_w = 1'b0;
  endtask

  // Load: combinational, sampled 1 ns after the inputs settle.
  task automatic rd(input string tag, input logic [31:0] a, input logic [2:0] op,
                    input logic [31:0] exp);
    addr = a; dm_op = op; dm_r = 1'b1;
    #1;
    chk(tag, rdata, exp);
    dm_r = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dm_w = 1'b0; dm_r = 1'b0; addr = '0; wdata = '0; dm_op = 3'b000;

    // Reset with a concurrent write that must be discarded
    dm_w = 1'b1; addr = 32'h10; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    rst = 1'b0; dm_w = 1'b0;
    rd("rst_rd", 32'h10, 3'b000, 32'h0000_0000);

    // Word store / load, addr[1:0] ignored for words
    wr(32'h20, 32'hDEADBEEF, 3'b000);
    rd("w_ld", 32'h20, 3'b000, 32'hDEADBEEF);
    rd("w_ld_unal", 32'h22, 3'b000, 32'hDEADBEEF);

    // dm_r = 0 forces rdata to 0 regardless of contents
    addr = 32'h20; dm_op = 3'b000; dm_r = 1'b0; #1;
    chk("rd_off", rdata, 32'h0);

    // Byte store into lane 1
    wr(32'h21, 32'h12345678, 3'b011);
    rd("b_st_word", 32'h20, 3'b000, 32'hDEAD78EF);
    rd("b_ld_s", 32'h21, 3'b011, 32'h0000_0078);
    rd("b_ld_u3", 32'h23, 3'b100, 32'h0000_00DE);

    // Sign / zero extension
    wr(32'h30, 32'h80F0FF85, 3'b000);
    rd("bs_neg", 32'h30, 3'b011, 32'hFFFFFF85);
    rd("bu_neg", 32'h30, 3'b100, 32'h0000_0085);
    rd("hs_hi", 32'h32, 3'b001, 32'hFFFF80F0);
    rd("hu_hi", 32'h32, 3'b010, 32'h0000_80F0);
    rd("hs_odd", 32'h31, 3'b001, 32'hFFFFFF85);
    rd("bu_2", 32'h32, 3'b100, 32'h0000_00F0);

    // Halfword store, upper lane
    wr(32'h32, 32'hAAAA5555, 3'b010);
    rd("h_st_word", 32'h30, 3'b000, 32'h5555FF85);
    rd("bs_pos", 32'h33, 3'b011, 32'h0000_0055);

    // Write disabled while wdata churns
    addr = 32'h30; dm_op = 3'b000; dm_w = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wdata = 32'h0F0F_0000 + i;
      @(posedge clk); #1;
    end
    rd("wdis", 32'h30, 3'b000, 32'h5555FF85);

    // Address wrap
    wr(32'h20 + 4 * (1 << AW), 32'h11111111, 3'b000);
    rd("wrap", 32'h20, 3'b000, 32'h11111111);
    rd("wrap_hi", 32'h8000_0020, 3'b000, 32'h11111111);

    // Reserved op codes behave as word
    wr(32'h50, 32'hA5A5C3C3, 3'b101);
    rd("op7", 32'h50, 3'b111, 32'hA5A5C3C3);

    // Read during write: old data before the edge, new data after
    addr = 32'h20; dm_op = 3'b000; wdata = 32'h22222222; dm_w = 1'b1; dm_r = 1'b1;
    #1;
    chk("rdw_old", rdata, 32'h11111111);
    @(posedge clk); #1;
    chk("rdw_new", rdata, 32'h22222222);
    dm_w = 1'b0; dm_r = 1'b0;

`ifdef DM_ALIGN_CHECK_EN
    wr(32'h40, 32'h01020304, 3'b000);
    addr = 32'h41; wdata = 32'hFFFFFFFF; dm_op = 3'b000; dm_w = 1'b1; #1;
    chk("mis_flag", {31'b0, misalign}, 32'h1);
    @(posedge clk); #1;
    dm_w = 1'b0;
    rd("mis_keep", 32'h40, 3'b000, 32'h01020304);
    rd("mis_rd", 32'h41, 3'b000, 32'h0);
`endif

    // Mid-sequence reset clears memory and drops the concurrent write
    rst = 1'b1; dm_w = 1'b1; addr = 32'h44; wdata = 32'h77777777; dm_op = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0; dm_w = 1'b0;
    rd("rst2_clr", 32'h20, 3'b000, 32'h0);
    rd("rst2_wr", 32'h44, 3'b000, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/dm.md
Name: dm

Overview:
- Data memory for the single-cycle MIPS CPU, in the MEM stage.
- Word-organised RAM supporting word, halfword and byte loads and stores, with sign or zero extension on loads.
- Reads are combinational. Writes and reset take effect on the rising clock edge.

Parameters:
- ADDR_W, 10, word-address width; depth = 2**ADDR_W 32-bit words (4 KiB default).
- INIT_ZERO, 1, when 1, reset clears every word; when 0, reset leaves memory contents untouched.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- dm_w  in  1  write enable.
- dm_r  in  1  read enable.
- addr  in  32  byte address.
- wdata  in  32  store data; the low byte/halfword is used for sub-word stores.
- dm_op  in  3  access size/extension code.
- rdata  out  32  load data.

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- dm_op encoding:
  - 000 word
  - 001 halfword signed
  - 010 halfword unsigned
  - 011 byte signed
  - 100 byte unsigned
  - 101–111 treated as word.
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·depth bytes.
- Little-endian lanes: byte k of a word = bits [8k+7:8k]. Halfword lane = addr[1] (0 → [15:0], 1 → [31:16]).
- Alignment:
  - Word accesses ignore addr[1:0].
  - Halfword accesses ignore addr[0].
  - Bytes use addr[1:0].
  - No exception is raised in the base build.
- Write, on posedge clk when dm_w=1 and rst=0:
  - word: mem[idx] <= wdata.
  - halfword (001/010): selected lane <= wdata[15:0]; other lanes unchanged.
  - byte (011/100): selected byte <= wdata[7:0]; others unchanged.
- Read, combinational:
  - dm_r=0 → rdata = 0.
  - dm_r=1 → the selected word/half/byte, sign- or zero-extended per dm_op.
- Read-during-write to the same address returns the old contents until the clock edge. rdata then reflects the new data in the same cycle after the edge.
- dm_r and dm_w may both be 1; this is legal.
- Reset:
  - While rst=1 at a posedge, writes are suppressed.
  - If INIT_ZERO=1, all words become 0 at that edge.
  - rdata is 0 after reset for any read (INIT_ZERO=1).
  - Reset asserted mid-sequence discards the concurrent write.

Optional Feature:
- Macro DM_ALIGN_CHECK_EN.
- When defined:
  - Adds output port misalign (1 bit).
  - misalign = dm_r|dm_w asserted with word access and addr[1:0]≠0, or halfword access and addr[0]=1. It is combinational.
  - A misaligned write is suppressed (memory unchanged).
  - A misaligned read returns 0.
- When undefined: no misalign port; addresses are silently aligned as above.

Decomposition:
- Package dm_pkg holds:
  - localparams DM_WORD=3'b000, DM_HALF_S=3'b001, DM_HALF_U=3'b010, DM_BYTE_S=3'b011, DM_BYTE_U=3'b100.
  - a helper function for extension.
- One sub-module, dm_lane, is natural. It is combinational and:
  - from dm_op and addr[1:0], produces a 4-bit byte-enable and the merged write word;
  - extracts and extends the load value from the raw word.
- dm itself holds the storage array, reset and write sequencing.

Test Plan:
- Reset then read: rst=1 for one edge; dm_r=1, dm_op=000, addr=0x10 → rdata=0x00000000. With dm_r=0, rdata=0 regardless of contents.
- Word store/load: store 0xDEADBEEF at addr 0x20 with op 000 → load 0x20 op 000 returns 0xDEADBEEF. Load 0x22 op 000 also returns 0xDEADBEEF.
- Byte store: after the above, store wdata=0x12345678 op 011 at 0x21 → word 0x20 = 0xDEAD78EF. Load 0x21 op 011 → 0x00000078.
- Sign/zero extension: word 0x30 = 0x80F0FF85.
  - load 0x30 op 011 → 0xFFFFFF85; op 100 → 0x00000085.
  - load 0x32 op 001 → 0xFFFF80F0; op 010 → 0x000080F0.
- Halfword store, upper lane: store wdata=0xAAAA5555 op 010 at 0x32 onto 0x80F0FF85 → word = 0x5555FF85.
- Write-disable and wrap: with dm_w=0 and wdata changing, memory is unchanged. Store 0x11111111 at addr 0x20+4·2**ADDR_W → load 0x20 returns 0x11111111.
- With DM_ALIGN_CHECK_EN: word store at 0x41 → misalign=1 and word 0x40 unchanged.
